// File: rtl/sdr_cmd_monitor.sv
// Purpose : passive SDRAM command snooper; decodes commands, tracks per-bank state/timers, flags protocol/timing violations, counts events.
// Latency : a command sampled at edge k shows up at edge k+1 on every output (cmd_*, bank_open, counters, viol*).
// Backpres: none; the monitor never stalls the bus it observes, it only reports.
//
// Ports:
//   sdram_clk, sdram_resetn            clock (rising edge), synchronous active-low reset
//   sdr_cs_n/ras_n/cas_n/we_n, sdr_ba,  snooped SDRAM command pins; sdr_addr[10] is the
//   sdr_addr                            auto-precharge / precharge-all flag
//   mon_en, clr_cnt                    enable counting + violation reporting; clear all counters
//   cmd_valid, cmd_code                registered decoded command (0 NOP .. 7 BST)
//   bank_open                          bit b set while bank b is ACTIVATING or ACTIVE
//   act/rd/wr/pre/ref/mrs_cnt          saturating per-command counters
//   viol, viol_code, viol_bank,        one-cycle violation pulse, sticky code/bank of the
//   viol_cnt                           last reported violation, saturating violation count
module sdr_cmd_monitor #(
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 13,
  parameter int CNT_W     = 16,
  parameter int T_RCD     = 3,
  parameter int T_RP      = 3,
  parameter int T_RAS     = 5,
  localparam int BA_W     = $clog2(NUM_BANKS)
) (
  input  logic                 sdram_clk,
  input  logic                 sdram_resetn,
  input  logic                 sdr_cs_n,
  input  logic                 sdr_ras_n,
  input  logic                 sdr_cas_n,
  input  logic                 sdr_we_n,
  input  logic [BA_W-1:0]      sdr_ba,
  input  logic [ADDR_W-1:0]    sdr_addr,
  input  logic                 mon_en,
  input  logic                 clr_cnt,
  output logic                 cmd_valid,
  output logic [2:0]           cmd_code,
  output logic [NUM_BANKS-1:0] bank_open,
  output logic [CNT_W-1:0]     act_cnt,
  output logic [CNT_W-1:0]     rd_cnt,
  output logic [CNT_W-1:0]     wr_cnt,
  output logic [CNT_W-1:0]     pre_cnt,
  output logic [CNT_W-1:0]     ref_cnt,
  output logic [CNT_W-1:0]     mrs_cnt,
  output logic                 viol,
  output logic [2:0]           viol_code,
  output logic [BA_W-1:0]      viol_bank,
  output logic [CNT_W-1:0]     viol_cnt
);

  // Command encodings as reported on cmd_code.
  localparam logic [2:0] CMD_NOP = 3'd0;
  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;
  localparam logic [2:0] CMD_MRS = 3'd6;
  localparam logic [2:0] CMD_BST = 3'd7;

  // Violation encodings as reported on viol_code.
  localparam logic [2:0] V_NONE      = 3'd0;
  localparam logic [2:0] V_ACT_OPEN  = 3'd1;
  localparam logic [2:0] V_RW_CLOSED = 3'd2;
  localparam logic [2:0] V_TRCD      = 3'd3;
  localparam logic [2:0] V_TRP       = 3'd4;
  localparam logic [2:0] V_TRAS      = 3'd5;
  localparam logic [2:0] V_REF_OPEN  = 3'd6;

  // Timers hold T_x-1 at most, so they only need enough bits for the largest T_x-1.
  localparam int T_MAX = (T_RCD > T_RP) ? ((T_RCD > T_RAS) ? T_RCD : T_RAS)
                                        : ((T_RP  > T_RAS) ? T_RP  : T_RAS);
  localparam int TW    = (T_MAX > 2) ? $clog2(T_MAX) : 1;

  localparam logic [TW-1:0] RCD_LD = TW'(T_RCD - 1);
  localparam logic [TW-1:0] RP_LD  = TW'(T_RP  - 1);
  localparam logic [TW-1:0] RAS_LD = TW'(T_RAS - 1);
  localparam logic [TW-1:0] T_ONE  = TW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    B_IDLE        = 2'd0,
    B_ACTIVATING  = 2'd1,
    B_ACTIVE      = 2'd2,
    B_PRECHARGING = 2'd3
  } bank_state_t;

  function automatic logic is_open(input bank_state_t s);
    return (s == B_ACTIVATING) || (s == B_ACTIVE);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Only bit 10 of the address carries meaning for command checking.
  logic unused_addr_bits;
  assign unused_addr_bits = ^sdr_addr;

  logic a10;
  assign a10 = sdr_addr[10];

  // ------------------------------------------------------------------
  // Command decode (combinational, sampled at the edge)
  // ------------------------------------------------------------------
  logic [2:0] dec_cmd;

  always_comb begin
    dec_cmd = CMD_NOP;
    if (!sdr_cs_n) begin
      case ({sdr_ras_n, sdr_cas_n, sdr_we_n})
        3'b011:  dec_cmd = CMD_ACT;
        3'b101:  dec_cmd = CMD_RD;
        3'b100:  dec_cmd = CMD_WR;
        3'b010:  dec_cmd = CMD_PRE;
        3'b001:  dec_cmd = CMD_REF;
        3'b000:  dec_cmd = CMD_MRS;
        3'b110:  dec_cmd = CMD_BST;
        default: dec_cmd = CMD_NOP;
      endcase
    end
  end

  // ------------------------------------------------------------------
  // Per-bank FSMs and timers
  // ------------------------------------------------------------------
  bank_state_t     bank_q [NUM_BANKS];
  bank_state_t     bank_d [NUM_BANKS];
  logic [TW-1:0]   rcd_q  [NUM_BANKS];
  logic [TW-1:0]   rcd_d  [NUM_BANKS];
  logic [TW-1:0]   rp_q   [NUM_BANKS];
  logic [TW-1:0]   rp_d   [NUM_BANKS];
  logic [TW-1:0]   ras_q  [NUM_BANKS];
  logic [TW-1:0]   ras_d  [NUM_BANKS];

  always_ff @(posedge sdram_clk) begin
    if (!sdram_resetn) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_q[b] <= B_IDLE;
        rcd_q[b]  <= '0;
        rp_q[b]   <= '0;
        ras_q[b]  <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_q[b] <= bank_d[b];
        rcd_q[b]  <= rcd_d[b];
        rp_q[b]   <= rp_d[b];
        ras_q[b]  <= ras_d[b];
      end
    end
  end

  // Violating commands still move state exactly like legal ones, so the
  // monitor keeps tracking what the real device would do afterwards.
  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      logic hit;
      hit = (sdr_ba == BA_W'(b));

      // Free-running countdown, saturating at zero.
      rcd_d[b]  = (rcd_q[b] != '0) ? rcd_q[b] - T_ONE : '0;
      rp_d[b]   = (rp_q[b]  != '0) ? rp_q[b]  - T_ONE : '0;
      ras_d[b]  = (ras_q[b] != '0) ? ras_q[b] - T_ONE : '0;
      bank_d[b] = bank_q[b];

      case (bank_q[b])
        B_ACTIVATING:  if (rcd_q[b] == '0) bank_d[b] = B_ACTIVE;
        B_PRECHARGING: if (rp_q[b] == '0)  bank_d[b] = B_IDLE;
        default:       bank_d[b] = bank_q[b];
      endcase

      // Command effects override the timer-driven transitions above.
      case (dec_cmd)
        CMD_ACT: begin
          if (hit) begin
            bank_d[b] = B_ACTIVATING;
            rcd_d[b]  = RCD_LD;
            ras_d[b]  = RAS_LD;
          end
        end
        CMD_RD, CMD_WR: begin
          // Auto-precharge closes the bank on the same edge; a RD/WR to a
          // closed bank leaves it untouched.
          if (hit && a10 && is_open(bank_q[b])) begin
            bank_d[b] = B_PRECHARGING;
            rp_d[b]   = RP_LD;
          end
        end
        CMD_PRE: begin
          if ((hit || a10) && is_open(bank_q[b])) begin
            bank_d[b] = B_PRECHARGING;
            rp_d[b]   = RP_LD;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_open[b] = is_open(bank_q[b]);
    end
  end

  // ------------------------------------------------------------------
  // Violation detection
  // ------------------------------------------------------------------
  bank_state_t   sel_state;
  logic [TW-1:0] sel_rcd;
  logic [TW-1:0] sel_rp;
  logic [TW-1:0] sel_ras;

  assign sel_state = bank_q[sdr_ba];
  assign sel_rcd   = rcd_q[sdr_ba];
  assign sel_rp    = rp_q[sdr_ba];
  assign sel_ras   = ras_q[sdr_ba];

  // Lowest-index bank with a running tRAS timer, and lowest non-IDLE bank.
  // Scanning downward lets the last hit be the lowest index.
  logic            ras_any;
  logic [BA_W-1:0] ras_low;
  logic            busy_any;
  logic [BA_W-1:0] busy_low;

  always_comb begin
    ras_any  = 1'b0;
    ras_low  = '0;
    busy_any = 1'b0;
    busy_low = '0;
    for (int b = NUM_BANKS - 1; b >= 0; b--) begin
      if (ras_q[b] != '0) begin
        ras_any = 1'b1;
        ras_low = BA_W'(b);
      end
      if (bank_q[b] != B_IDLE) begin
        busy_any = 1'b1;
        busy_low = BA_W'(b);
      end
    end
  end

  logic            viol_det;
  logic [2:0]      viol_code_d;
  logic [BA_W-1:0] viol_bank_d;

  always_comb begin
    viol_det    = 1'b0;
    viol_code_d = V_NONE;
    viol_bank_d = sdr_ba;
    case (dec_cmd)
      CMD_ACT: begin
        if (is_open(sel_state)) begin
          viol_det    = 1'b1;
          viol_code_d = V_ACT_OPEN;
        end else if (sel_rp != '0) begin
          viol_det    = 1'b1;
          viol_code_d = V_TRP;
        end
      end
      CMD_RD, CMD_WR: begin
        if (!is_open(sel_state)) begin
          viol_det    = 1'b1;
          viol_code_d = V_RW_CLOSED;
        end else if (sel_rcd != '0) begin
          viol_det    = 1'b1;
          viol_code_d = V_TRCD;
        end
      end
      CMD_PRE: begin
        if (a10) begin
          if (ras_any) begin
            viol_det    = 1'b1;
            viol_code_d = V_TRAS;
            viol_bank_d = ras_low;
          end
        end else if (sel_ras != '0) begin
          viol_det    = 1'b1;
          viol_code_d = V_TRAS;
        end
      end
      CMD_REF, CMD_MRS: begin
        if (busy_any) begin
          viol_det    = 1'b1;
          viol_code_d = V_REF_OPEN;
          viol_bank_d = busy_low;
        end
      end
      default: ;
    endcase
  end

  // ------------------------------------------------------------------
  // Registered outputs and counters
  // ------------------------------------------------------------------
  logic report;
  assign report = mon_en && viol_det;

  always_ff @(posedge sdram_clk) begin
    if (!sdram_resetn) begin
      cmd_valid <= 1'b0;
      cmd_code  <= CMD_NOP;
      viol      <= 1'b0;
      viol_code <= V_NONE;
      viol_bank <= '0;
      act_cnt   <= '0;
      rd_cnt    <= '0;
      wr_cnt    <= '0;
      pre_cnt   <= '0;
      ref_cnt   <= '0;
      mrs_cnt   <= '0;
      viol_cnt  <= '0;
    end else begin
      cmd_valid <= (dec_cmd != CMD_NOP);
      cmd_code  <= dec_cmd;
      viol      <= report;
      // Code and bank are sticky: they only change when a new violation is reported.
      if (report) begin
        viol_code <= viol_code_d;
        viol_bank <= viol_bank_d;
      end

      if (clr_cnt) begin
        act_cnt  <= '0;
        rd_cnt   <= '0;
        wr_cnt   <= '0;
        pre_cnt  <= '0;
        ref_cnt  <= '0;
        mrs_cnt  <= '0;
        viol_cnt <= '0;
      end else if (mon_en) begin
        case (dec_cmd)
          CMD_ACT: act_cnt <= sat_inc(act_cnt);
          CMD_RD:  rd_cnt  <= sat_inc(rd_cnt);
          CMD_WR:  wr_cnt  <= sat_inc(wr_cnt);
          CMD_PRE: pre_cnt <= sat_inc(pre_cnt);
          CMD_REF: ref_cnt <= sat_inc(ref_cnt);
          CMD_MRS: mrs_cnt <= sat_inc(mrs_cnt);
          default: ;
        endcase
        if (viol_det) viol_cnt <= sat_inc(viol_cnt);
      end
    end
  end

endmodule

// File: tb/tb_sdr_cmd_monitor.sv
// Purpose : directed table-driven bench for sdr_cmd_monitor plus hand-written reset and counter-saturation sequences.
// Latency : inputs driven on the falling edge, outputs checked on the next falling edge (one command per cycle).
// Backpres: none; stimulus is a fixed script.
module tb_sdr_cmd_monitor;

  localparam logic [2:0] K_NOP = 3'd0;
  localparam logic [2:0] K_ACT = 3'd1;
  localparam logic [2:0] K_RD  = 3'd2;
  localparam logic [2:0] K_WR  = 3'd3;
  localparam logic [2:0] K_PRE = 3'd4;
  localparam logic [2:0] K_REF = 3'd5;
  localparam logic [2:0] K_MRS = 3'd6;
  localparam logic [2:0] K_BST = 3'd7;

  logic        clk;
  logic        resetn;
  logic        cs_n, ras_n, cas_n, we_n;
  logic [1:0]  ba;
  logic [12:0] addr;
  logic        mon_en, clr_cnt;

  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic [3:0]  bank_open;
  logic [15:0] act_cnt, rd_cnt, wr_cnt, pre_cnt, ref_cnt, mrs_cnt, viol_cnt;
  logic        viol;
  logic [2:0]  viol_code;
  logic [1:0]  viol_bank;

  logic        u4_unused_cmd_valid;
  logic [2:0]  u4_unused_cmd_code;
  logic [3:0]  u4_unused_bank_open;
  logic [3:0]  d4_act_cnt, d4_pre_cnt, d4_viol_cnt;
  logic [3:0]  u4_unused_rd, u4_unused_wr, u4_unused_ref, u4_unused_mrs;
  logic        u4_unused_viol;
  logic [2:0]  u4_unused_viol_code;
  logic [1:0]  u4_unused_viol_bank;

  sdr_cmd_monitor dut (
    .sdram_clk(clk), .sdram_resetn(resetn),
    .sdr_cs_n(cs_n), .sdr_ras_n(ras_n), .sdr_cas_n(cas_n), .sdr_we_n(we_n),
    .sdr_ba(ba), .sdr_addr(addr), .mon_en(mon_en), .clr_cnt(clr_cnt),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .bank_open(bank_open),
    .act_cnt(act_cnt), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt), .pre_cnt(pre_cnt),
    .ref_cnt(ref_cnt), .mrs_cnt(mrs_cnt),
    .viol(viol), .viol_code(viol_code), .viol_bank(viol_bank), .viol_cnt(viol_cnt)
  );

  // Narrow-counter instance on the same pins, used for saturation checks.
  sdr_cmd_monitor #(.CNT_W(4)) dut4 (
    .sdram_clk(clk), .sdram_resetn(resetn),
    .sdr_cs_n(cs_n), .sdr_ras_n(ras_n), .sdr_cas_n(cas_n), .sdr_we_n(we_n),
    .sdr_ba(ba), .sdr_addr(addr), .mon_en(mon_en), .clr_cnt(clr_cnt),
    .cmd_valid(u4_unused_cmd_valid), .cmd_code(u4_unused_cmd_code), .bank_open(u4_unused_bank_open),
    .act_cnt(d4_act_cnt), .rd_cnt(u4_unused_rd), .wr_cnt(u4_unused_wr), .pre_cnt(d4_pre_cnt),
    .ref_cnt(u4_unused_ref), .mrs_cnt(u4_unused_mrs),
    .viol(u4_unused_viol), .viol_code(u4_unused_viol_code), .viol_bank(u4_unused_viol_bank),
    .viol_cnt(d4_viol_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] cmd;
    logic [1:0] ba;
    logic       a10, ds, en, clr;
    logic [2:0] code;
    logic       vi;
    logic [2:0] vcode;
    logic [1:0] vbank;
    logic [3:0] open;
    int         vcnt, act, rd, wr, pre, rf, mrs;
  } vec_t;

  localparam int NV = 42;
  vec_t tbl [NV];

  int n_chk  = 0;
  int n_pass = 0;

  function automatic vec_t mk(input logic [2:0] c, input int b, a10, ds, en, clr,
                              code, vi, vcode, vbank, input logic [3:0] open,
                              input int vcnt, act, rd, wr, pre, rf, mrs);
    vec_t r;
    r.cmd = c;          r.ba = 2'(b);        r.a10 = 1'(a10);  r.ds = 1'(ds);
    r.en = 1'(en);      r.clr = 1'(clr);     r.code = 3'(code); r.vi = 1'(vi);
    r.vcode = 3'(vcode); r.vbank = 2'(vbank); r.open = open;
    r.vcnt = vcnt; r.act = act; r.rd = rd; r.wr = wr; r.pre = pre; r.rf = rf; r.mrs = mrs;
    return r;
  endfunction

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
  endtask

  // Drive one command for one cycle, then land on the next falling edge.
  task automatic drive(input logic [2:0] c, input logic [1:0] b, input logic a10,
                       input logic ds, input logic en, input logic clr);
    logic [2:0] p;
    case (c)
      K_ACT:   p = 3'b011;
      K_RD:    p = 3'b101;
      K_WR:    p = 3'b100;
      K_PRE:   p = 3'b010;
      K_REF:   p = 3'b001;
      K_MRS:   p = 3'b000;
      K_BST:   p = 3'b110;
      default: p = 3'b111;
    endcase
    cs_n = (c == K_NOP) || ds;
    {ras_n, cas_n, we_n} = p;
    ba      = b;
    addr    = {2'b00, a10, 10'h155};
    mon_en  = en;
    clr_cnt = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // cmd ba a10 ds en clr | code viol vcode vbank open | vcnt act rd wr pre ref mrs
    tbl[0]  = mk(K_ACT,2,0,0,1,0, 1,0,0,0,4'b0100,  0, 1,0,0,0,0,0);
    tbl[1]  = mk(K_NOP,0,0,0,1,0, 0,0,0,0,4'b0100,  0, 1,0,0,0,0,0);
    tbl[2]  = mk(K_NOP,0,0,0,1,0, 0,0,0,0,4'b0100,  0, 1,0,0,0,0,0);
    tbl[3]  = mk(K_RD ,2,0,0,1,0, 2,0,0,0,4'b0100,  0, 1,1,0,0,0,0);
    tbl[4]  = mk(K_ACT,1,0,0,1,0, 1,0,0,0,4'b0110,  0, 2,1,0,0,0,0);
    tbl[5]  = mk(K_NOP,0,0,0,1,0, 0,0,0,0,4'b0110,  0, 2,1,0,0,0,0);
    tbl[6]  = mk(K_RD ,1,0,0,1,0, 2,1,3,1,4'b0110,  1, 2,2,0,0,0,0);
    tbl[7]  = mk(K_ACT,0,0,0,1,0, 1,0,3,1,4'b0111,  1, 3,2,0,0,0,0);
    tbl[8]  = mk(K_NOP,0,0,0,1,0, 0,0,3,1,4'b0111,  1, 3,2,0,0,0,0);
    tbl[9]  = mk(K_NOP,0,0,0,1,0, 0,0,3,1,4'b0111,  1, 3,2,0,0,0,0);
    tbl[10] = mk(K_NOP,0,0,0,1,0, 0,0,3,1,4'b0111,  1, 3,2,0,0,0,0);
    tbl[11] = mk(K_PRE,0,0,0,1,0, 4,1,5,0,4'b0110,  2, 3,2,0,1,0,0);
    tbl[12] = mk(K_NOP,0,0,0,1,0, 0,0,5,0,4'b0110,  2, 3,2,0,1,0,0);
    tbl[13] = mk(K_ACT,0,0,0,1,0, 1,1,4,0,4'b0111,  3, 4,2,0,1,0,0);
    tbl[14] = mk(K_ACT,2,0,0,1,0, 1,1,1,2,4'b0111,  4, 5,2,0,1,0,0);
    tbl[15] = mk(K_NOP,0,0,0,1,0, 0,0,1,2,4'b0111,  4, 5,2,0,1,0,0);
    tbl[16] = mk(K_NOP,0,0,0,1,0, 0,0,1,2,4'b0111,  4, 5,2,0,1,0,0);
    tbl[17] = mk(K_NOP,0,0,0,1,0, 0,0,1,2,4'b0111,  4, 5,2,0,1,0,0);
    tbl[18] = mk(K_PRE,0,1,0,1,0, 4,1,5,2,4'b0000,  5, 5,2,0,2,0,0);
    tbl[19] = mk(K_REF,0,0,0,1,0, 5,1,6,0,4'b0000,  6, 5,2,0,2,1,0);
    tbl[20] = mk(K_NOP,0,0,0,1,0, 0,0,6,0,4'b0000,  6, 5,2,0,2,1,0);
    tbl[21] = mk(K_NOP,0,0,0,1,0, 0,0,6,0,4'b0000,  6, 5,2,0,2,1,0);
    tbl[22] = mk(K_REF,0,0,0,1,0, 5,0,6,0,4'b0000,  6, 5,2,0,2,2,0);
    tbl[23] = mk(K_ACT,1,0,0,1,0, 1,0,6,0,4'b0010,  6, 6,2,0,2,2,0);
    tbl[24] = mk(K_ACT,3,0,0,1,0, 1,0,6,0,4'b1010,  6, 7,2,0,2,2,0);
    tbl[25] = mk(K_REF,0,0,0,1,0, 5,1,6,1,4'b1010,  7, 7,2,0,2,3,0);
    tbl[26] = mk(K_NOP,0,0,0,1,0, 0,0,6,1,4'b1010,  7, 7,2,0,2,3,0);
    tbl[27] = mk(K_NOP,0,0,0,1,0, 0,0,6,1,4'b1010,  7, 7,2,0,2,3,0);
    tbl[28] = mk(K_NOP,0,0,0,1,0, 0,0,6,1,4'b1010,  7, 7,2,0,2,3,0);
    tbl[29] = mk(K_PRE,0,1,0,1,0, 4,0,6,1,4'b0000,  7, 7,2,0,3,3,0);
    tbl[30] = mk(K_ACT,0,0,0,1,0, 1,0,6,1,4'b0001,  7, 8,2,0,3,3,0);
    tbl[31] = mk(K_WR ,3,0,0,1,0, 3,1,2,3,4'b0001,  8, 8,2,1,3,3,0);
    tbl[32] = mk(K_WR ,2,0,0,0,0, 3,0,2,3,4'b0001,  8, 8,2,1,3,3,0);
    tbl[33] = mk(K_ACT,2,0,0,0,0, 1,0,2,3,4'b0101,  8, 8,2,1,3,3,0);
    tbl[34] = mk(K_ACT,2,0,0,0,0, 1,0,2,3,4'b0101,  8, 8,2,1,3,3,0);
    tbl[35] = mk(K_NOP,0,0,0,1,0, 0,0,2,3,4'b0101,  8, 8,2,1,3,3,0);
    tbl[36] = mk(K_BST,0,0,0,1,0, 7,0,2,3,4'b0101,  8, 8,2,1,3,3,0);
    tbl[37] = mk(K_MRS,0,0,0,1,0, 6,1,6,0,4'b0101,  9, 8,2,1,3,3,1);
    tbl[38] = mk(K_RD ,0,1,0,1,0, 2,0,6,0,4'b0100,  9, 8,3,1,3,3,1);
    tbl[39] = mk(K_ACT,0,0,0,1,0, 1,1,4,0,4'b0101, 10, 9,3,1,3,3,1);
    tbl[40] = mk(K_ACT,3,0,1,1,0, 0,0,4,0,4'b0101, 10, 9,3,1,3,3,1);
    tbl[41] = mk(K_ACT,3,0,0,1,1, 1,0,4,0,4'b1101,  0, 0,0,0,0,0,0);

    // Reset with idle pins.
    resetn = 1'b0; cs_n = 1'b1; {ras_n, cas_n, we_n} = 3'b111;
    ba = '0; addr = '0; mon_en = 1'b1; clr_cnt = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset cmd_valid", int'(cmd_valid), 0);
    chk("reset bank_open", int'(bank_open), 0);
    chk("reset viol",      int'(viol), 0);
    chk("reset viol_code", int'(viol_code), 0);
    chk("reset viol_cnt",  int'(viol_cnt), 0);
    chk("reset act_cnt",   int'(act_cnt), 0);
    resetn = 1'b1;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].cmd, tbl[i].ba, tbl[i].a10, tbl[i].ds, tbl[i].en, tbl[i].clr);
      chk($sformatf("v%0d cmd_code", i),  int'(cmd_code),  int'(tbl[i].code));
      chk($sformatf("v%0d cmd_valid", i), int'(cmd_valid), (tbl[i].code != 3'd0) ? 1 : 0);
      chk($sformatf("v%0d viol", i),      int'(viol),      int'(tbl[i].vi));
      chk($sformatf("v%0d viol_code", i), int'(viol_code), int'(tbl[i].vcode));
      chk($sformatf("v%0d viol_bank", i), int'(viol_bank), int'(tbl[i].vbank));
      chk($sformatf("v%0d bank_open", i), int'(bank_open), int'(tbl[i].open));
      chk($sformatf("v%0d viol_cnt", i),  int'(viol_cnt),  tbl[i].vcnt);
      chk($sformatf("v%0d act_cnt", i),   int'(act_cnt),   tbl[i].act);
      chk($sformatf("v%0d rd_cnt", i),    int'(rd_cnt),    tbl[i].rd);
      chk($sformatf("v%0d wr_cnt", i),    int'(wr_cnt),    tbl[i].wr);
      chk($sformatf("v%0d pre_cnt", i),   int'(pre_cnt),   tbl[i].pre);
      chk($sformatf("v%0d ref_cnt", i),   int'(ref_cnt),   tbl[i].rf);
      chk($sformatf("v%0d mrs_cnt", i),   int'(mrs_cnt),   tbl[i].mrs);
    end

    // Reset in the middle of traffic discards open-bank state at once.
    drive(K_ACT, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("pre-rst bank_open", int'(bank_open), 4'b1111);
    chk("pre-rst act_cnt",   int'(act_cnt), 1);
    resetn = 1'b0;
    drive(K_ACT, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("midrst bank_open", int'(bank_open), 0);
    chk("midrst cmd_valid", int'(cmd_valid), 0);
    chk("midrst cmd_code",  int'(cmd_code), 0);
    chk("midrst viol_code", int'(viol_code), 0);
    chk("midrst act_cnt",   int'(act_cnt), 0);
    resetn = 1'b1;
    drive(K_ACT, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("postrst viol",      int'(viol), 0);
    chk("postrst bank_open", int'(bank_open), 4'b0100);
    chk("postrst act_cnt",   int'(act_cnt), 1);

    // 17 back-to-back ACT/PRE pairs on bank 0: every PRE breaks tRAS and
    // every ACT after the first breaks tRP, so 33 violations in total.
    for (int i = 0; i < 17; i++) begin
      drive(K_ACT, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      drive(K_PRE, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    chk("sat d4 act_cnt",   int'(d4_act_cnt), 15);
    chk("sat d4 pre_cnt",   int'(d4_pre_cnt), 15);
    chk("sat d4 viol_cnt",  int'(d4_viol_cnt), 15);
    chk("sat d16 act_cnt",  int'(act_cnt), 18);
    chk("sat d16 pre_cnt",  int'(pre_cnt), 17);
    chk("sat d16 viol_cnt", int'(viol_cnt), 33);

    // Clear wins over a simultaneous increment.
    drive(K_ACT, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("clr d4 act_cnt",   int'(d4_act_cnt), 0);
    chk("clr d4 viol_cnt",  int'(d4_viol_cnt), 0);
    chk("clr d16 act_cnt",  int'(act_cnt), 0);
    drive(K_ACT, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("after clr d4 act_cnt", int'(d4_act_cnt), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
